// File: rtl/vga_block_pkg.sv
// Shared types and constants for the vga_block rectangle overlay stage.
// The border feature is selected by the VGA_BLOCK_BORDER_EN macro in vga_block_draw.
package vga_block_pkg;

  localparam int CW     = 11;
  localparam int EN_BIT = 0;
  localparam int BD_BIT = 1;

  typedef logic [11:0] rgb_t;

  typedef struct packed {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic [CW-1:0] w;
    logic [CW-1:0] h;
  } rect_t;

endpackage

// File: rtl/vga_block_span.sv
// One-axis span compare: is count inside [pos, pos+len), and is it on either end.
// The end is formed in W+1 bits so a span running past the counter range never wraps.
module vga_block_span #(
  parameter int W = 11
) (
  input  logic [W-1:0] pos,
  input  logic [W-1:0] len,
  input  logic [W-1:0] count,
  output logic         in_span,
  output logic         at_edge
);

  logic [W:0] end_pos;

  assign end_pos = {1'b0, pos} + {1'b0, len};
  assign in_span = (count >= pos) && ({1'b0, count} < end_pos);
  // For len == 0 the last-pixel compare can match, but in_span is false, so it is gated off upstream.
  assign at_edge = (count == pos) || ({1'b0, count} == end_pos - (W+1)'(1));

endmodule

// File: rtl/vga_block_draw.sv
// Overlays one filled (optionally bordered) rectangle on the VGA pixel stream, 2-clock latency.
// Define VGA_BLOCK_BORDER_EN to compile in the border colour logic.
module vga_block_draw #(
  parameter int CW       = vga_block_pkg::CW,
  parameter int V_ACTIVE = 480
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   slv_reg0,
  input  logic [31:0]   slv_reg1,
  input  logic [31:0]   slv_reg2,
  input  logic [31:0]   slv_reg3,
  input  logic [CW-1:0] hcount_in,
  input  logic [CW-1:0] vcount_in,
  input  logic          hsync_in,
  input  logic          vsync_in,
  input  logic          blank_in,
  input  logic [11:0]   rgb_in,
  output logic          hsync_out,
  output logic          vsync_out,
  output logic          blank_out,
  output logic [11:0]   rgb_out,
  output logic          frame_tick
);

  import vga_block_pkg::*;

  rect_t sh_rect;
  rgb_t  sh_fill;
  logic  sh_en;

  logic  load;
  logic  x_in, x_edge, y_in, y_edge;
  logic  hit, hit_d;
  rgb_t  rgb_d, rgb_next;
  logic  hs_d, vs_d, blank_d;

`ifdef VGA_BLOCK_BORDER_EN
  rgb_t  sh_border;
  logic  sh_bd;
  logic  on_edge_d;
`endif

  // Line V_ACTIVE is in vertical blanking, so swapping the shadow set here is tear-free.
  assign load = (vcount_in == CW'(V_ACTIVE)) && (hcount_in == '0);

  vga_block_span #(.W(CW)) u_span_x (
    .pos     (CW'(sh_rect.x)),
    .len     (CW'(sh_rect.w)),
    .count   (hcount_in),
    .in_span (x_in),
    .at_edge (x_edge)
  );

  vga_block_span #(.W(CW)) u_span_y (
    .pos     (CW'(sh_rect.y)),
    .len     (CW'(sh_rect.h)),
    .count   (vcount_in),
    .in_span (y_in),
    .at_edge (y_edge)
  );

  assign hit = sh_en & x_in & y_in;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values;
  // this is also what makes a same-cycle load and pixel compare see the old shadow set.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_rect    <= '0;
      sh_fill    <= '0;
      sh_en      <= 1'b0;
      frame_tick <= 1'b0;
`ifdef VGA_BLOCK_BORDER_EN
      sh_border  <= '0;
      sh_bd      <= 1'b0;
`endif
    end else begin
      frame_tick <= load;
      if (load) begin
        sh_rect.x <= slv_reg0[10:0];
        sh_rect.y <= slv_reg0[26:16];
        sh_rect.w <= slv_reg1[10:0];
        sh_rect.h <= slv_reg1[26:16];
        sh_fill   <= slv_reg2[11:0];
        sh_en     <= slv_reg3[EN_BIT];
`ifdef VGA_BLOCK_BORDER_EN
        sh_border <= slv_reg2[27:16];
        sh_bd     <= slv_reg3[BD_BIT];
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_d     <= 1'b0;
      rgb_d     <= '0;
      hs_d      <= 1'b0;
      vs_d      <= 1'b0;
      blank_d   <= 1'b0;
      rgb_out   <= '0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
      blank_out <= 1'b0;
`ifdef VGA_BLOCK_BORDER_EN
      on_edge_d <= 1'b0;
`endif
    end else begin
      hit_d     <= hit;
      rgb_d     <= rgb_in;
      hs_d      <= hsync_in;
      vs_d      <= vsync_in;
      blank_d   <= blank_in;
      rgb_out   <= rgb_next;
      hsync_out <= hs_d;
      vsync_out <= vs_d;
      blank_out <= blank_d;
`ifdef VGA_BLOCK_BORDER_EN
      on_edge_d <= hit & (x_edge | y_edge);
`endif
    end
  end

  // NOTE: rgb_next gets a default before any branch, so no latch can be inferred.
  always_comb begin
    rgb_next = rgb_d;
    if (blank_d) begin
      rgb_next = '0;
`ifdef VGA_BLOCK_BORDER_EN
    end else if (on_edge_d && sh_bd) begin
      rgb_next = sh_border;
`endif
    end else if (hit_d) begin
      rgb_next = sh_fill;
    end
  end

  logic unused_bits;
`ifdef VGA_BLOCK_BORDER_EN
  assign unused_bits = ^{slv_reg0[31:27], slv_reg0[15:11], slv_reg1[31:27], slv_reg1[15:11],
                         slv_reg2[31:28], slv_reg2[15:12], slv_reg3[31:2]};
`else
  assign unused_bits = ^{slv_reg0[31:27], slv_reg0[15:11], slv_reg1[31:27], slv_reg1[15:11],
                         slv_reg2[31:12], slv_reg3[31:1], x_edge, y_edge};
`endif

endmodule

// File: tb/tb_vga_block_draw.sv
// Scoreboard bench for vga_block_draw: a reference model predicts each pixel, checked 2 clocks later.
// Border expectations follow VGA_BLOCK_BORDER_EN so the bench works in either build.
module tb_vga_block_draw;

  import vga_block_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] slv_reg0, slv_reg1, slv_reg2, slv_reg3;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, vsync_in, blank_in;
  logic [11:0] rgb_in;
  logic        hsync_out, vsync_out, blank_out, frame_tick;
  logic [11:0] rgb_out;

  always #5 clk = ~clk;

  vga_block_draw dut (
    .clk        (clk),
    .rst        (rst),
    .slv_reg0   (slv_reg0),
    .slv_reg1   (slv_reg1),
    .slv_reg2   (slv_reg2),
    .slv_reg3   (slv_reg3),
    .hcount_in  (hcount_in),
    .vcount_in  (vcount_in),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .blank_in   (blank_in),
    .rgb_in     (rgb_in),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out),
    .blank_out  (blank_out),
    .rgb_out    (rgb_out),
    .frame_tick (frame_tick)
  );

  typedef struct {
    int   h;
    int   v;
    rgb_t rgb;
    logic hs;
    logic vs;
    logic bl;
    logic ld;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference shadow state, updated only when a load pixel is driven.
  int   m_x, m_y, m_w, m_h;
  rgb_t m_fill, m_border;
  logic m_en, m_bd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic rgb_t model_rgb(input int h, input int v, input logic bl, input rgb_t bg);
    logic hit;
    hit = m_en && (h >= m_x) && (h < m_x + m_w) && (v >= m_y) && (v < m_y + m_h);
    if (bl) return 12'h000;
`ifdef VGA_BLOCK_BORDER_EN
    if (m_bd && hit && (h == m_x || h == m_x + m_w - 1 || v == m_y || v == m_y + m_h - 1))
      return m_border;
`endif
    if (hit) return m_fill;
    return bg;
  endfunction

  function automatic logic [31:0] pack(input int hi, input int lo);
    return {5'b0, 11'(hi), 5'b0, 11'(lo)};
  endfunction

  task automatic clear_model();
    m_x = 0; m_y = 0; m_w = 0; m_h = 0;
    m_fill = '0; m_border = '0; m_en = 1'b0; m_bd = 1'b0;
  endtask

  task automatic apply(input int h, input int v, input logic bl, input logic hs, input logic vs);
    exp_t e;
    rgb_t bg;
    bg        = 12'h5A5 ^ 12'(h + v * 3);
    hcount_in = 11'(h);
    vcount_in = 11'(v);
    blank_in  = bl;
    hsync_in  = hs;
    vsync_in  = vs;
    rgb_in    = bg;
    e.h   = h;
    e.v   = v;
    e.rgb = model_rgb(h, v, bl, bg);
    e.hs  = hs;
    e.vs  = vs;
    e.bl  = bl;
    e.ld  = (v == 480) && (h == 0);
    sb.push_back(e);
    if (e.ld) begin
      m_x      = int'(slv_reg0[10:0]);
      m_y      = int'(slv_reg0[26:16]);
      m_w      = int'(slv_reg1[10:0]);
      m_h      = int'(slv_reg1[26:16]);
      m_fill   = slv_reg2[11:0];
      m_border = slv_reg2[27:16];
      m_en     = slv_reg3[EN_BIT];
      m_bd     = slv_reg3[BD_BIT];
    end
  endtask

  // Outputs seen at a falling edge belong to the pixel applied two falling edges earlier.
  task automatic px(input int h, input int v, input logic bl = 1'b0,
                    input logic hs = 1'b0, input logic vs = 1'b0);
    exp_t e;
    @(negedge clk);
    if (sb.size() == 2) begin
      e = sb.pop_front();
      check($sformatf("rgb(%0d,%0d)", e.h, e.v), 32'(rgb_out), 32'(e.rgb));
      check($sformatf("hsync(%0d,%0d)", e.h, e.v), 32'(hsync_out), 32'(e.hs));
      check($sformatf("vsync(%0d,%0d)", e.h, e.v), 32'(vsync_out), 32'(e.vs));
      check($sformatf("blank(%0d,%0d)", e.h, e.v), 32'(blank_out), 32'(e.bl));
    end
    check($sformatf("frame_tick(%0d,%0d)", h, v), 32'(frame_tick),
          32'((sb.size() > 0) ? sb[$].ld : 1'b0));
    apply(h, v, bl, hs, vs);
  endtask

  // Registers change just after a rising edge, so the pixel already applied was sampled with the old values.
  task automatic set_regs(input logic [31:0] r0, input logic [31:0] r1,
                          input logic [31:0] r2, input logic [31:0] r3);
    @(posedge clk);
    #1;
    slv_reg0 = r0;
    slv_reg1 = r1;
    slv_reg2 = r2;
    slv_reg3 = r3;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    hcount_in = 11'd0;
    vcount_in = 11'd480;
    hsync_in  = 1'b1;
    vsync_in  = 1'b1;
    blank_in  = 1'b0;
    rgb_in    = 12'hFFF;
    repeat (3) @(negedge clk);
    check("rst_rgb", 32'(rgb_out), 32'h0);
    check("rst_hsync", 32'(hsync_out), 32'h0);
    check("rst_vsync", 32'(vsync_out), 32'h0);
    check("rst_blank", 32'(blank_out), 32'h0);
    check("rst_tick", 32'(frame_tick), 32'h0);
    sb.delete();
    clear_model();
    rst = 1'b0;
    apply(0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic load_frame();
    px(0, 479, 1'b1);
    px(0, 480, 1'b1, 1'b0, 1'b1);
    px(1, 480, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    rst       = 1'b0;
    slv_reg0  = '0;
    slv_reg1  = '0;
    slv_reg2  = '0;
    slv_reg3  = '0;
    hcount_in = '0;
    vcount_in = '0;
    hsync_in  = 1'b0;
    vsync_in  = 1'b0;
    blank_in  = 1'b0;
    rgb_in    = '0;
    clear_model();

    // Register values present at reset must not load even though the load condition is driven.
    slv_reg0 = pack(50, 100);
    slv_reg3 = 32'h1;
    do_reset();
    px(105, 55);

    // Basic fill
    set_regs(pack(50, 100), pack(10, 20), 32'h0000_0F00, 32'h1);
    px(105, 55);
    load_frame();
    px(100, 50); px(119, 59); px(120, 50); px(99, 50); px(110, 55); px(110, 60);
    check("basic_model_fill", 32'(m_fill), 32'hF00);

    // Tear-free update: new x waits for the next load
    px(100, 200);
    set_regs(pack(50, 300), pack(10, 20), 32'h0000_0F00, 32'h1);
    px(100, 55); px(300, 55); px(0, 479); px(1, 480, 1'b1);
    load_frame();
    px(300, 55); px(319, 55); px(100, 55);

    // Border, plus a one-pixel-wide rectangle
    set_regs(pack(50, 100), pack(10, 20), 32'h00F0_0F00, 32'h3);
    load_frame();
    px(100, 55); px(119, 55); px(110, 50); px(110, 59); px(110, 55); px(101, 51);
    set_regs(pack(50, 100), pack(10, 1), 32'h00F0_0F00, 32'h3);
    load_frame();
    px(100, 55); px(101, 55); px(99, 55);

    // Clipping and overflow of x + w
    set_regs(pack(50, 630), pack(10, 2047), 32'h0000_0F00, 32'h1);
    load_frame();
    for (int h = 628; h < 642; h++) px(h, 50);
    px(0, 50); px(1, 50); px(2046, 50); px(2047, 50);

    // Width 0 and height 0 draw nothing
    set_regs(pack(50, 630), pack(10, 0), 32'h0000_0F00, 32'h1);
    load_frame();
    px(630, 50); px(631, 50); px(629, 50);
    set_regs(pack(50, 100), pack(0, 20), 32'h0000_0F00, 32'h1);
    load_frame();
    px(100, 50); px(105, 50);

    // Blanking and sync latency
    set_regs(pack(50, 100), pack(10, 20), 32'h0000_0F00, 32'h1);
    load_frame();
    px(105, 55, 1'b1); px(105, 55);
    px(106, 55, 1'b0, 1'b1); px(107, 55, 1'b0, 1'b1); px(108, 55, 1'b0, 1'b0);
    px(109, 55, 1'b0, 1'b1, 1'b1); px(110, 55, 1'b0, 1'b0, 1'b0);

    // Reset mid-frame: drawing stays off until the next load
    do_reset();
    px(105, 55); px(100, 50);
    load_frame();
    px(105, 55); px(100, 50);

    px(0, 0); px(0, 0); px(0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
